pwm_modulator: RTL and testbench
================================

# pwm_modulator

Converts the 8-bit sample stream from the sine sample source into a single-bit PWM waveform for the DAC output pin, where an external RC filter reconstructs the analogue signal. Sits directly downstream of the sample source. One duty sample is consumed per PWM period through a valid/ready handshake and a one-deep shadow buffer. The new duty value is applied only at period boundaries, so the waveform never glitches mid-period.

## Interface
Parameters:
- PRESCALE, 1, system clocks per PWM count step; legal range 1..65535.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous active-high reset.
- sample_in  input  8  unsigned duty sample, 0..255.
- sample_valid  input  1  sample_in is valid this cycle.
- sample_ready  output  1  shadow buffer empty; a sample is accepted when valid & ready.
- pwm_out  output  1  registered PWM output.
- period_start  output  1  one-cycle pulse on the first cycle of each PWM period.
- underrun  output  1  one-cycle pulse when a period boundary finds the shadow buffer empty.
- underrun_count  output  16  saturating count of underrun events.

## Operation
- pre_cnt counts 0..PRESCALE-1. It wraps to 0 on the cycle where tick = (pre_cnt == PRESCALE-1). With PRESCALE=1, tick is always 1.
- pwm_cnt is 8 bits and increments by 1 on tick, wrapping 255 -> 0.
- Period = 256 × PRESCALE clocks.
- boundary = tick & (pwm_cnt == 255).
- Handshake:
  - sample_ready = !shadow_full. It is a registered-state decode with no combinational path from sample_valid.
  - On valid & ready: shadow <= sample_in, shadow_full <= 1.
  - While ready = 0, sample_in is ignored and the shadow contents are never overwritten.
- Boundary with shadow_full = 1:
  - duty <= shadow, shadow_full <= 0.
  - sample_ready rises the next cycle.
- Boundary with shadow_full = 0:
  - duty holds its previous value (the last sample repeats).
  - underrun pulses high for 1 cycle.
  - underrun_count increments, saturating at 0xFFFF.
- Simultaneous accept and boundary with the shadow empty:
  - The accepted sample goes to shadow only; duty holds and underrun pulses.
  - The sample is applied at the next boundary.
- Duty encoding: pwm_out is high while pwm_cnt < duty.
  - duty 0 -> constant low.
  - duty 255 -> high 255 of 256 counts.
  - 100% duty is not representable.
- Arithmetic: all compares are unsigned 8-bit. There is no wider intermediate result.

## Timing
- Reset values (cycle after rst sampled high):
  - pre_cnt = 0, pwm_cnt = 0, duty = 0.
  - shadow = 0, shadow_full = 0.
  - pwm_out = 0, period_start = 0, underrun = 0, underrun_count = 0.
  - sample_ready = 1.
- rst has priority over all activity. Asserting it mid-period discards the shadow buffer and duty, and restarts the period from count 0 on the first cycle after release.
- pwm_out latency: pwm_out(t+1) = (pwm_cnt(t) < duty(t)). The waveform is delayed by exactly 1 clock relative to the counter.
- period_start(t+1) = boundary(t). It pulses on the first cycle that pwm_cnt == 0 of each new period. It does not pulse on the first period after reset.
- A sample accepted at cycle t reaches pwm_out no earlier than the boundary following t, plus 1 cycle.
- Throughput: at most one accepted sample per period.
- underrun is coincident with period_start. underrun_count updates in the same cycle that underrun is high.
- First boundary after reset, with PRESCALE=1, occurs at cycle 255 after release. If no sample has been accepted by then, underrun pulses.

## Test plan
- PRESCALE=1; reset; offer sample 64 held valid. Expected:
  - Accepted on cycle 0; sample_ready = 0 until cycle 256.
  - From the second period on, pwm_out is high for exactly 64 consecutive cycles, then low for 192.
  - No underrun after the sample is accepted.
- PRESCALE=1; samples 0, then 255, each supplied in time for its boundary -> pwm_out is low for the full period carrying 0, then high 255 / low 1 for the period carrying 255.
- PRESCALE=1; a single sample 128, then sample_valid held low:
  - Duty stays 128 every period.
  - underrun and period_start pulse together once per 256 cycles.
  - underrun_count reads 3 after three empty boundaries.
- Backpressure:
  - Present 10 (accepted).
  - Then hold sample_valid high with sample_in = 200 while ready = 0; 200 is not captured.
  - 10 is applied at the boundary. 200 is accepted the cycle after ready rises and is applied at the following boundary.
- PRESCALE=4, sample 32 -> period is 1024 clocks; pwm_out is high for 128 consecutive clocks; period_start is spaced 1024 clocks apart.
- Assert rst for 1 cycle mid-period (pwm_cnt ≈ 100, duty 64, shadow full). Expected:
  - All outputs return to reset values: pwm_out = 0, sample_ready = 1, underrun_count = 0.
  - The counter restarts at 0.
  - The old shadow sample is never output.

Source files
------------

// File: rtl/pwm_modulator.sv
// ---------------------------------------------------------------------------
// pwm_modulator
//
// Turns a stream of 8-bit unsigned duty samples into a single-bit PWM
// waveform.  One sample is consumed per PWM period through a valid/ready
// handshake backed by a one-deep shadow buffer.  The active duty value only
// changes at a period boundary, so a period is never cut short or stretched
// by a new sample arriving mid-period.
//
// Parameters
//   PRESCALE        system clocks per PWM count step (1..65535)
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   sample_in       duty sample, 0..255
//   sample_valid    sample_in is valid this cycle
//   sample_ready    shadow buffer empty; accept happens on valid & ready
//   pwm_out         registered PWM output (high while count < duty)
//   period_start    one-cycle pulse on the first cycle of each new period
//   underrun        one-cycle pulse when a boundary finds the shadow empty
//   underrun_count  saturating count of underrun events
// ---------------------------------------------------------------------------
module pwm_modulator #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        pwm_out,
  output logic        period_start,
  output logic        underrun,
  output logic [15:0] underrun_count
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0] r_pre_cnt;
  logic [7:0]  r_pwm_cnt;
  logic [7:0]  r_duty;
  logic [7:0]  r_shadow;
  logic        r_shadow_full;
  logic        r_pwm_out;
  logic        r_period_start;
  logic        r_underrun;
  logic [15:0] r_underrun_count;

  logic w_tick;
  logic w_boundary;
  logic w_accept;
  logic w_empty_boundary;

  always_comb begin
    w_tick           = (r_pre_cnt == PRE_MAX);
    w_boundary       = w_tick & (r_pwm_cnt == 8'hFF);
    // Ready is a pure decode of registered state, never of sample_valid.
    w_accept         = sample_valid & ~r_shadow_full;
    w_empty_boundary = w_boundary & ~r_shadow_full;
  end

  // Prescaler and PWM counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt <= 16'd0;
      r_pwm_cnt <= 8'd0;
    end else begin
      r_pre_cnt <= w_tick ? 16'd0 : r_pre_cnt + 16'd1;
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end
    end
  end

  // Shadow buffer and active duty.  A boundary with a full shadow drains it;
  // an accept can only happen while the shadow is empty, so the two never
  // compete.  An accept coinciding with an empty boundary lands in the
  // shadow only and waits for the next boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty        <= 8'd0;
      r_shadow      <= 8'd0;
      r_shadow_full <= 1'b0;
    end else if (w_boundary && r_shadow_full) begin
      r_duty        <= r_shadow;
      r_shadow_full <= 1'b0;
    end else if (w_accept) begin
      r_shadow      <= sample_in;
      r_shadow_full <= 1'b1;
    end
  end

  // Output stage: everything is one clock behind the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_out        <= 1'b0;
      r_period_start   <= 1'b0;
      r_underrun       <= 1'b0;
      r_underrun_count <= 16'd0;
    end else begin
      r_pwm_out      <= (r_pwm_cnt < r_duty);
      r_period_start <= w_boundary;
      r_underrun     <= w_empty_boundary;
      if (w_empty_boundary && (r_underrun_count != 16'hFFFF)) begin
        r_underrun_count <= r_underrun_count + 16'd1;
      end
    end
  end

  assign sample_ready   = ~r_shadow_full;
  assign pwm_out        = r_pwm_out;
  assign period_start   = r_period_start;
  assign underrun       = r_underrun;
  assign underrun_count = r_underrun_count;

endmodule

// File: tb/tb_pwm_modulator.sv
// ---------------------------------------------------------------------------
// tb_pwm_modulator
//
// Drives two instances side by side (PRESCALE = 1 and PRESCALE = 4), each with
// its own sample stream, and compares every output every cycle against a
// reference model that derives the counter position directly from the
// number of clocks since reset release.  Directed scenarios add whole-period
// high-time and underrun-count checks; a randomized tail mixes starvation
// and backpressure.
// ---------------------------------------------------------------------------
module tb_pwm_modulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  sample_in      [2];
  logic        sample_valid   [2];
  logic        sample_ready   [2];
  logic        pwm_out        [2];
  logic        period_start   [2];
  logic        underrun       [2];
  logic [15:0] underrun_count [2];

  pwm_modulator #(.PRESCALE(1)) u_dut0 (
    .clk            (clk),
    .rst            (rst),
    .sample_in      (sample_in[0]),
    .sample_valid   (sample_valid[0]),
    .sample_ready   (sample_ready[0]),
    .pwm_out        (pwm_out[0]),
    .period_start   (period_start[0]),
    .underrun       (underrun[0]),
    .underrun_count (underrun_count[0])
  );

  pwm_modulator #(.PRESCALE(4)) u_dut1 (
    .clk            (clk),
    .rst            (rst),
    .sample_in      (sample_in[1]),
    .sample_valid   (sample_valid[1]),
    .sample_ready   (sample_ready[1]),
    .pwm_out        (pwm_out[1]),
    .period_start   (period_start[1]),
    .underrun       (underrun[1]),
    .underrun_count (underrun_count[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model state.  m_n is the index of the current cycle counted
  // from reset release; the PWM count position is (m_n / P) mod 256.
  int presc [2] = '{1, 4};
  int m_n      [2];
  int m_duty   [2];
  int m_shadow [2];
  bit m_full   [2];
  int m_ucnt   [2];
  bit e_pwm    [2];
  bit e_ps     [2];
  bit e_ur     [2];
  int hi_acc   [2];

  task automatic model_edge(input int d);
    int  cnt;
    bit  bnd;
    bit  acc;
    if (rst) begin
      m_n[d] = 0; m_duty[d] = 0; m_shadow[d] = 0; m_full[d] = 0;
      m_ucnt[d] = 0; e_pwm[d] = 0; e_ps[d] = 0; e_ur[d] = 0;
      return;
    end
    cnt = (m_n[d] / presc[d]) % 256;
    bnd = ((m_n[d] % presc[d]) == presc[d] - 1) && (cnt == 255);
    acc = sample_valid[d] && !m_full[d];
    e_pwm[d] = (cnt < m_duty[d]);
    e_ps[d]  = bnd;
    e_ur[d]  = bnd && !m_full[d];
    if (bnd && m_full[d]) begin
      m_duty[d] = m_shadow[d];
      m_full[d] = 0;
    end else begin
      if (bnd && m_ucnt[d] < 65535) m_ucnt[d] = m_ucnt[d] + 1;
      if (acc) begin
        m_shadow[d] = sample_in[d];
        m_full[d]   = 1;
      end
    end
    m_n[d] = m_n[d] + 1;
  endtask

  // One clock: advance the model on the pre-edge view, then compare.
  task automatic step();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d pwm_out n=%0d", d, m_n[d]), 32'(pwm_out[d]), 32'(e_pwm[d]));
      check($sformatf("d%0d period_start n=%0d", d, m_n[d]), 32'(period_start[d]), 32'(e_ps[d]));
      check($sformatf("d%0d underrun n=%0d", d, m_n[d]), 32'(underrun[d]), 32'(e_ur[d]));
      check($sformatf("d%0d underrun_count n=%0d", d, m_n[d]), 32'(underrun_count[d]), 32'(m_ucnt[d]));
      check($sformatf("d%0d sample_ready n=%0d", d, m_n[d]), 32'(sample_ready[d]), 32'(!m_full[d]));
      if (pwm_out[d] === 1'b1) hi_acc[d]++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      sample_in[d] = 8'd0; sample_valid[d] = 1'b0; hi_acc[d] = 0; m_n[d] = 0;
    end

    // Held samples: 64 at PRESCALE=1, 32 at PRESCALE=4.
    do_reset();
    sample_in[0] = 8'd64; sample_valid[0] = 1'b1;
    sample_in[1] = 8'd32; sample_valid[1] = 1'b1;
    run(600);
    hi_acc[0] = 0; run(256);
    check("held64 high_per_period", 32'(hi_acc[0]), 32'd64);
    run(400);
    hi_acc[1] = 0; run(1024);
    check("p4 held32 high_per_period", 32'(hi_acc[1]), 32'd128);
    check("held64 no_underrun", 32'(underrun_count[0]), 32'd0);
    check("p4 held32 no_underrun", 32'(underrun_count[1]), 32'd0);
    $display("TXN held-samples done n=%0d", m_n[0]);

    // Single sample 128, then starve: three empty boundaries.
    do_reset();
    sample_in[0] = 8'd128; sample_valid[0] = 1'b1; sample_valid[1] = 1'b0;
    step();
    sample_valid[0] = 1'b0;
    run(1029);
    check("starve underrun_count", 32'(underrun_count[0]), 32'd3);
    $display("TXN starve done ucnt=%0d", underrun_count[0]);

    // Duty 0 then duty 255.
    do_reset();
    sample_in[0] = 8'd0; sample_valid[0] = 1'b1;
    step();
    sample_valid[0] = 1'b0;
    run(255);
    sample_in[0] = 8'd255; sample_valid[0] = 1'b1;
    step();
    sample_valid[0] = 1'b0;
    hi_acc[0] = 0; run(255);
    check("duty0 high", 32'(hi_acc[0]), 32'd0);
    hi_acc[0] = 0; run(256);
    check("duty255 high", 32'(hi_acc[0]), 32'd255);
    $display("TXN duty-extremes done");

    // Backpressure: 10 accepted, 200 held while not ready.
    do_reset();
    sample_in[0] = 8'd10; sample_valid[0] = 1'b1;
    step();
    sample_in[0] = 8'd200;
    run(255);
    hi_acc[0] = 0; run(256);
    check("backpressure first=10", 32'(hi_acc[0]), 32'd10);
    hi_acc[0] = 0; run(256);
    check("backpressure second=200", 32'(hi_acc[0]), 32'd200);
    $display("TXN backpressure done");

    // Reset mid-period with duty 64 active and the shadow full.
    do_reset();
    sample_in[0] = 8'd64; sample_valid[0] = 1'b1;
    run(356);
    sample_valid[0] = 1'b0;
    check("midrst shadow_full_before", 32'(sample_ready[0]), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst ready", 32'(sample_ready[0]), 32'd1);
    check("midrst pwm", 32'(pwm_out[0]), 32'd0);
    check("midrst ucnt", 32'(underrun_count[0]), 32'd0);
    hi_acc[0] = 0; run(600);
    check("midrst old_sample_never_output", 32'(hi_acc[0]), 32'd0);
    $display("TXN midreset done");

    // Randomized: sparse offers (underruns) then dense offers (backpressure).
    do_reset();
    for (int i = 0; i < 8000; i++) begin
      for (int d = 0; d < 2; d++) begin
        sample_in[d]    = 8'($urandom_range(0, 255));
        sample_valid[d] = (i < 4000) ? ($urandom_range(0, 999) < 3)
                                     : ($urandom_range(0, 99) < 30);
      end
      step();
    end
    $display("TXN random done ucnt0=%0d ucnt1=%0d", underrun_count[0], underrun_count[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
